// File: rtl/vga_scroll_pattern.sv
// vga_scroll_pattern
//   Scrolling test-pattern generator placed between the sync/timing
//   generator and the PMOD RGB mapping. It advances a scroll offset once
//   per frame and turns (hpos, vpos, offset) into one of four patterns.
//   RGB and the syncs leave through a single register stage, so they
//   stay aligned with each other.
//
// Ports
//   clk, rst_n       pixel clock, asynchronous active-low reset
//   hsync_in/vsync_in syncs from the timing generator
//   display_on       visible-area flag (RGB is forced to 0 outside it)
//   hpos, vpos       current pixel coordinate
//   mode             pattern select (takes effect at the next frame start)
//   speed, dir       offset step per frame and its direction
//   freeze           hold the offset (sampled at frame start)
//   hsync_out/vsync_out syncs delayed by one clock
//   r, g, b          2-bit colour channels, one clock of latency
//   frame_tick       one-cycle pulse at the edge where the offset updates
//   offset           current scroll offset
module vga_scroll_pattern #(
    parameter int COORD_W   = 10,
    parameter int CNT_W     = 10,
    parameter int BAR_SHIFT = 5,
    parameter int SYNC_POL  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               display_on,
    input  logic [COORD_W-1:0] hpos,
    input  logic [COORD_W-1:0] vpos,
    input  logic [1:0]         mode,
    input  logic [2:0]         speed,
    input  logic               dir,
    input  logic               freeze,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [1:0]         r,
    output logic [1:0]         g,
    output logic [1:0]         b,
    output logic               frame_tick,
    output logic [CNT_W-1:0]   offset
);

    localparam int  S       = BAR_SHIFT;
    localparam logic ACTIVE = SYNC_POL[0];

    logic               vs_d;
    logic               frame_start;
    logic [1:0]         mode_q;
    logic [2:0]         speed_q;
    logic               dir_q;
    logic [CNT_W-1:0]   step;
    logic [COORD_W-1:0] o, mx, my, x;
    logic [1:0]         pat_r, pat_g, pat_b;

    // Frame start is the clock where vsync first shows its active level.
    // vs_d resets to the inactive level, so a vsync already active when
    // reset releases counts as a frame start on the first clock.
    assign frame_start = (vsync_in == ACTIVE) && (vs_d != ACTIVE);

    assign step = {{(CNT_W-3){1'b0}}, speed};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d       <= ~ACTIVE;
            mode_q     <= '0;
            speed_q    <= '0;
            dir_q      <= 1'b0;
            offset     <= '0;
            frame_tick <= 1'b0;
        end else begin
            vs_d       <= vsync_in;
            frame_tick <= frame_start;
            if (frame_start) begin
                mode_q  <= mode;
                speed_q <= speed;
                dir_q   <= dir;
                // Offset step uses the live inputs, not the shadow copies.
                if (!freeze)
                    offset <= dir ? offset - step : offset + step;
            end
        end
    end

    // speed_q/dir_q are kept as a frame-stable snapshot of the controls;
    // pattern logic only consumes mode_q and the partial coordinate bits.
    logic unused_bits;
    assign unused_bits = ^{speed_q, dir_q, mx, my, x, offset};

    assign o  = offset[COORD_W-1:0];
    assign mx = hpos + o;
    assign my = vpos + o;
    assign x  = mx ^ my;

    always_comb begin
        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        case (mode_q)
            2'd0: begin
                pat_r = {mx[S],   vpos[2]};
                pat_g = {mx[S+1], vpos[2]};
                pat_b = {mx[S+2], vpos[5]};
            end
            2'd1: begin
                pat_r = {my[S],   hpos[2]};
                pat_g = {my[S+1], hpos[2]};
                pat_b = {my[S+2], hpos[5]};
            end
            2'd2: begin
                pat_r = {2{mx[S] ^ my[S]}};
                pat_g = pat_r;
                pat_b = pat_r;
            end
            default: begin
                pat_r = x[S:S-1];
                pat_g = x[S+2:S+1];
                pat_b = x[S+4:S+3];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_out <= ~ACTIVE;
            vsync_out <= ~ACTIVE;
            r         <= '0;
            g         <= '0;
            b         <= '0;
        end else begin
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
            r         <= display_on ? pat_r : 2'b00;
            g         <= display_on ? pat_g : 2'b00;
            b         <= display_on ? pat_b : 2'b00;
        end
    end

endmodule
